// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, ALU functions, condition codes,
// status codes and the "no register" ID.
package y86_pkg;
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;

  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  localparam logic [3:0] S_AOK = 4'h1;
  localparam logic [3:0] S_HLT = 4'h2;
  localparam logic [3:0] S_ADR = 4'h3;
  localparam logic [3:0] S_INS = 4'h4;

  localparam logic [3:0] RNONE = 4'hF;
endpackage

// File: rtl/alu_core.sv
// Combinational Y86-64 ALU: add/sub/and/xor with ZF/SF/OF.
module alu_core
  import y86_pkg::*;
#(
  parameter int WORD = 64
) (
  input  logic [WORD-1:0] a,
  input  logic [WORD-1:0] b,
  input  logic [3:0]      fun,
  output logic [WORD-1:0] res,
  output logic            zf,
  output logic            sf,
  output logic            of
);
  always_comb begin
    res = '0;
    of  = 1'b0;
    case (fun)
      ALU_ADD: begin
        res = b + a;
        of  = (a[WORD-1] == b[WORD-1]) && (res[WORD-1] != a[WORD-1]);
      end
      ALU_SUB: begin
        res = b - a;
        of  = (a[WORD-1] != b[WORD-1]) && (res[WORD-1] != b[WORD-1]);
      end
      ALU_AND: res = a & b;
      ALU_XOR: res = a ^ b;
      default: res = '0;
    endcase
  end

  assign zf = (res == '0);
  assign sf = res[WORD-1];
endmodule

// File: rtl/execute_stage.sv
// Y86-64 Execute stage: operand select, ALU, condition codes, Cnd evaluation
// and the E->M pipeline register.
module execute_stage
  import y86_pkg::*;
#(
  parameter int         WORD     = 64,
  parameter int         RID_W    = 4,
  parameter logic [2:0] CC_RESET = 3'b100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       E_stat,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_ifun,
  input  logic [WORD-1:0]  E_valC,
  input  logic [WORD-1:0]  E_valA,
  input  logic [WORD-1:0]  E_valB,
  input  logic [RID_W-1:0] E_dstE,
  input  logic [RID_W-1:0] E_dstM,
  input  logic [3:0]       m_stat,
  input  logic [3:0]       W_stat,
  input  logic             M_stall,
  input  logic             M_bubble,
  output logic [WORD-1:0]  e_valE,
  output logic [RID_W-1:0] e_dstE,
  output logic             e_Cnd,
  output logic [2:0]       cc,
  output logic [3:0]       M_stat,
  output logic [3:0]       M_icode,
  output logic             M_Cnd,
  output logic [WORD-1:0]  M_valE,
  output logic [WORD-1:0]  M_valA,
  output logic [RID_W-1:0] M_dstE,
  output logic [RID_W-1:0] M_dstM
);
  typedef struct packed {
    logic [3:0]       stat;
    logic [3:0]       icode;
    logic             cnd;
    logic [WORD-1:0]  vale;
    logic [WORD-1:0]  vala;
    logic [RID_W-1:0] dste;
    logic [RID_W-1:0] dstm;
  } em_reg_t;

  localparam em_reg_t EM_BUBBLE = '{stat: S_AOK, icode: I_NOP, cnd: 1'b0,
                                    vale: '0, vala: '0, dste: '1, dstm: '1};

  logic [WORD-1:0] alua, alub;
  logic [3:0]      alufun;
  logic            zf_n, sf_n, of_n, set_cc;
  logic            zf, sf, of;
  em_reg_t         m_q, m_d;

  always_comb begin
    alua = '0;
    case (E_icode)
      I_RRMOVQ, I_OPQ:                alua = E_valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:   alua = E_valC;
      I_CALL, I_PUSHQ:                alua = '0 - WORD'(8);
      I_RET, I_POPQ:                  alua = WORD'(8);
      default:                        alua = '0;
    endcase
  end

  always_comb begin
    alub = '0;
    case (E_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alub = E_valB;
      default:                                                  alub = '0;
    endcase
  end

  assign alufun = (E_icode == I_OPQ) ? E_ifun : ALU_ADD;

  alu_core #(.WORD(WORD)) u_alu (
    .a(alua), .b(alub), .fun(alufun),
    .res(e_valE), .zf(zf_n), .sf(sf_n), .of(of_n)
  );

  // Flags are suppressed while a later stage is reporting an exception.
  assign set_cc = (E_icode == I_OPQ) && (E_ifun <= ALU_XOR) &&
                  (m_stat == S_AOK) && (W_stat == S_AOK);

  always_ff @(posedge clk) begin
    if (rst)         cc <= CC_RESET;
    else if (set_cc) cc <= {zf_n, sf_n, of_n};
  end

  assign {zf, sf, of} = cc;

  always_comb begin
    e_Cnd = 1'b0;
    case (E_ifun)
      C_YES:   e_Cnd = 1'b1;
      C_LE:    e_Cnd = (sf ^ of) | zf;
      C_L:     e_Cnd = sf ^ of;
      C_E:     e_Cnd = zf;
      C_NE:    e_Cnd = ~zf;
      C_GE:    e_Cnd = ~(sf ^ of);
      C_G:     e_Cnd = ~(sf ^ of) & ~zf;
      default: e_Cnd = 1'b0;
    endcase
  end

  assign e_dstE = ((E_icode == I_RRMOVQ) && !e_Cnd) ? {RID_W{1'b1}} : E_dstE;

  assign m_d = '{stat: E_stat, icode: E_icode, cnd: e_Cnd, vale: e_valE,
                 vala: E_valA, dste: e_dstE, dstm: E_dstM};

  always_ff @(posedge clk) begin
    if (rst)           m_q <= EM_BUBBLE;
    else if (M_stall)  m_q <= m_q;
    else if (M_bubble) m_q <= EM_BUBBLE;
    else               m_q <= m_d;
  end

  assign M_stat  = m_q.stat;
  assign M_icode = m_q.icode;
  assign M_Cnd   = m_q.cnd;
  assign M_valE  = m_q.vale;
  assign M_valA  = m_q.vala;
  assign M_dstE  = m_q.dste;
  assign M_dstM  = m_q.dstm;
endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: reference model predicts e_* and the
// next E->M register contents, compared one cycle later.
module tb_execute_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  E_stat, E_icode, E_ifun;
  logic [63:0] E_valC, E_valA, E_valB;
  logic [3:0]  E_dstE, E_dstM, m_stat, W_stat;
  logic        M_stall, M_bubble;
  logic [63:0] e_valE;
  logic [3:0]  e_dstE;
  logic        e_Cnd;
  logic [2:0]  cc;
  logic [3:0]  M_stat, M_icode;
  logic        M_Cnd;
  logic [63:0] M_valE, M_valA;
  logic [3:0]  M_dstE, M_dstM;

  always #5 clk = ~clk;

  execute_stage dut (
    .clk(clk), .rst(rst), .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB), .E_dstE(E_dstE),
    .E_dstM(E_dstM), .m_stat(m_stat), .W_stat(W_stat), .M_stall(M_stall),
    .M_bubble(M_bubble), .e_valE(e_valE), .e_dstE(e_dstE), .e_Cnd(e_Cnd),
    .cc(cc), .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd),
    .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM)
  );

  typedef struct {
    logic [3:0]  stat, icode;
    logic        cnd;
    logic [63:0] vale, vala;
    logic [3:0]  dste, dstm;
  } mexp_t;

  mexp_t       q[$];
  mexp_t       m_model;
  logic [2:0]  cc_model;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic mexp_t bubble();
    mexp_t b;
    b.stat = 4'h1; b.icode = 4'h1; b.cnd = 1'b0;
    b.vale = '0; b.vala = '0; b.dste = 4'hF; b.dstm = 4'hF;
    return b;
  endfunction

  task automatic step(input logic [3:0] st, ic, fn, input logic [63:0] vc, va, vb,
                      input logic [3:0] de, dm, ms, ws,
                      input logic stall, bub, r);
    logic [63:0] a, b, res;
    logic [64:0] wide;
    logic        zf, sf, of, cnd, upd;
    logic [3:0]  dste;
    mexp_t       nx, got;
    E_stat = st; E_icode = ic; E_ifun = fn; E_valC = vc; E_valA = va; E_valB = vb;
    E_dstE = de; E_dstM = dm; m_stat = ms; W_stat = ws;
    M_stall = stall; M_bubble = bub; rst = r;
    #1;
    case (ic)
      4'h2, 4'h6:       a = va;
      4'h3, 4'h4, 4'h5: a = vc;
      4'h8, 4'hA:       a = 64'hFFFF_FFFF_FFFF_FFF8;
      4'h9, 4'hB:       a = 64'd8;
      default:          a = 64'd0;
    endcase
    b = (ic inside {4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB}) ? vb : 64'd0;
    of = 1'b0;
    if (ic != 4'h6 || fn == 4'h0) begin
      wide = {b[63], b} + {a[63], a};
      res = wide[63:0]; of = wide[64] ^ wide[63];
    end else if (fn == 4'h1) begin
      wide = {b[63], b} - {a[63], a};
      res = wide[63:0]; of = wide[64] ^ wide[63];
    end else if (fn == 4'h2) res = a & b;
    else if (fn == 4'h3)     res = a ^ b;
    else                     res = 64'd0;
    zf = (res == 64'd0); sf = res[63];
    upd = (ic == 4'h6) && (fn < 4'd4) && (ms == 4'h1) && (ws == 4'h1);
    case (fn)
      4'h0: cnd = 1'b1;
      4'h1: cnd = cc_model[0] != cc_model[1] || cc_model[2];
      4'h2: cnd = cc_model[0] != cc_model[1];
      4'h3: cnd = cc_model[2];
      4'h4: cnd = !cc_model[2];
      4'h5: cnd = cc_model[0] == cc_model[1];
      4'h6: cnd = cc_model[0] == cc_model[1] && !cc_model[2];
      default: cnd = 1'b0;
    endcase
    dste = (ic == 4'h2 && !cnd) ? 4'hF : de;
    check("e_valE", e_valE, res);
    check("e_Cnd", {63'd0, e_Cnd}, {63'd0, cnd});
    check("e_dstE", {60'd0, e_dstE}, {60'd0, dste});
    nx.stat = st; nx.icode = ic; nx.cnd = cnd; nx.vale = res;
    nx.vala = va; nx.dste = dste; nx.dstm = dm;
    if (r)          m_model = bubble();
    else if (stall) m_model = m_model;
    else if (bub)   m_model = bubble();
    else            m_model = nx;
    q.push_back(m_model);
    if (r)        cc_model = 3'b100;
    else if (upd) cc_model = {zf, sf, of};
    @(posedge clk); #1;
    got = q.pop_front();
    check("M_stat", {60'd0, M_stat}, {60'd0, got.stat});
    check("M_icode", {60'd0, M_icode}, {60'd0, got.icode});
    check("M_Cnd", {63'd0, M_Cnd}, {63'd0, got.cnd});
    check("M_valE", M_valE, got.vale);
    check("M_valA", M_valA, got.vala);
    check("M_dstE", {60'd0, M_dstE}, {60'd0, got.dste});
    check("M_dstM", {60'd0, M_dstM}, {60'd0, got.dstm});
    check("cc", {61'd0, cc}, {61'd0, cc_model});
  endtask

  initial begin
    // 1: reset
    step(4'h1, 4'h6, 4'h0, 64'd0, 64'd3, 64'd4, 4'h1, 4'h2, 4'h1, 4'h1, 1'b0, 1'b0, 1'b1);
    check("rst_cc", {61'd0, cc}, 64'd4);
    check("rst_icode", {60'd0, M_icode}, 64'd1);
    check("rst_stat", {60'd0, M_stat}, 64'd1);
    check("rst_dstE", {60'd0, M_dstE}, 64'hF);
    check("rst_dstM", {60'd0, M_dstM}, 64'hF);
    check("rst_valE", M_valE, 64'd0);
    // 2: add overflow
    step(4'h1, 4'h6, 4'h0, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'h3, 4'hF, 4'h1, 4'h1, 1'b0, 1'b0, 1'b0);
    check("add_valE", M_valE, 64'h8000_0000_0000_0000);
    check("add_cc", {61'd0, cc}, 64'b011);
    // 4: and to zero, then a gated add with W_stat=HLT
    step(4'h1, 4'h6, 4'h2, 64'd0, 64'hB, 64'h4, 4'h3, 4'hF, 4'h1, 4'h1, 1'b0, 1'b0, 1'b0);
    check("and_cc", {61'd0, cc}, 64'b100);
    step(4'h1, 4'h6, 4'h0, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'h3, 4'hF, 4'h1, 4'h2, 1'b0, 1'b0, 1'b0);
    check("hlt_cc_hold", {61'd0, cc}, 64'b100);
    // 3: sub to zero, then cmovne
    step(4'h1, 4'h6, 4'h1, 64'd0, 64'd5, 64'd5, 4'h3, 4'hF, 4'h1, 4'h1, 1'b0, 1'b0, 1'b0);
    check("sub_cc", {61'd0, cc}, 64'b100);
    step(4'h1, 4'h2, 4'h4, 64'd0, 64'd9, 64'd0, 4'h5, 4'hF, 4'h1, 4'h1, 1'b0, 1'b0, 1'b0);
    check("cmovne_dstE", {60'd0, M_dstE}, 64'hF);
    // 5: stack pointer arithmetic
    step(4'h1, 4'hA, 4'h0, 64'd0, 64'd7, 64'h100, 4'h4, 4'hF, 4'h1, 4'h1, 1'b0, 1'b0, 1'b0);
    check("pushq_valE", M_valE, 64'hF8);
    step(4'h1, 4'hB, 4'h0, 64'd0, 64'd7, 64'h100, 4'h4, 4'h6, 4'h1, 4'h1, 1'b0, 1'b0, 1'b0);
    check("popq_valE", M_valE, 64'h108);
    // 6: stall/bubble/reset priority
    step(4'h3, 4'h5, 4'h0, 64'h40, 64'd1, 64'h20, 4'hF, 4'h2, 4'h1, 4'h1, 1'b1, 1'b1, 1'b0);
    check("stall_hold_valE", M_valE, 64'h108);
    step(4'h3, 4'h5, 4'h0, 64'h40, 64'd1, 64'h20, 4'hF, 4'h2, 4'h1, 4'h1, 1'b0, 1'b1, 1'b0);
    step(4'h3, 4'h5, 4'h0, 64'h40, 64'd1, 64'h20, 4'hF, 4'h2, 4'h1, 4'h1, 1'b0, 1'b0, 1'b0);
    step(4'h1, 4'h6, 4'h1, 64'd0, 64'd1, 64'd0, 4'h1, 4'hF, 4'h1, 4'h1, 1'b1, 1'b0, 1'b1);
    // randomized mix of instructions and pipeline control
    for (int i = 0; i < 200; i++) begin
      logic [63:0] va, vb, vc;
      va = {$urandom, $urandom}; vb = {$urandom, $urandom}; vc = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) va = vb;
      if ($urandom_range(0, 5) == 0) vb = 64'h8000_0000_0000_0000;
      step(4'($urandom_range(1, 4)), 4'($urandom_range(0, 11)),
           4'(($urandom_range(0, 7) == 0) ? $urandom_range(7, 15) : $urandom_range(0, 6)),
           vc, va, vb, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 7) == 0) ? 4'h3 : 4'h1,
           ($urandom_range(0, 7) == 0) ? 4'h4 : 4'h1,
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 31) == 0));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
